// File: rtl/qspi_pkg.sv
// rtl/qspi_pkg.sv - shared opcodes, states and lane encodings for the QSPI target
package qspi_pkg;

  localparam logic [7:0] OP_READ          = 8'h03;
  localparam logic [7:0] OP_FAST_READ     = 8'h0B;
  localparam logic [7:0] OP_QUAD_OUT_READ = 8'h6B;
  localparam logic [7:0] OP_READ_STATUS   = 8'h05;

  // Same lane-select encoding as the qspi_fsm initiator.
  localparam logic [1:0] LANE_SINGLE = 2'b00;
  localparam logic [1:0] LANE_QUAD   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_IGNORE
  } state_t;

  function automatic logic [3:0] lane_oe(input logic [1:0] lane);
    return (lane == LANE_QUAD) ? 4'hF : 4'b0010;
  endfunction

endpackage

// File: rtl/qspi_pin_sync.sv
// rtl/qspi_pin_sync.sv - 2-flop synchronizers and sclk edge detect for the QSPI pads
module qspi_pin_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk_i,
  input  logic       cs_n_i,
  input  logic [3:0] io_i,
  output logic       sclk_rise,
  output logic       sclk_fall,
  output logic       cs_n_s,
  output logic [3:0] io_s
);

  logic [2:0] sclk_q;
  logic [1:0] cs_q;
  logic [3:0] io_q1;
  logic [3:0] io_q2;

  // cs_n resets to the selected level so a select held low through reset never reads as fresh.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_q <= 3'b000;
      cs_q   <= 2'b00;
      io_q1  <= 4'h0;
      io_q2  <= 4'h0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk_i};
      cs_q   <= {cs_q[0], cs_n_i};
      io_q1  <= io_i;
      io_q2  <= io_q1;
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_n_s    = cs_q[1];
  assign io_s      = io_q2;

endmodule

// File: rtl/qspi_target_responder.sv
// rtl/qspi_target_responder.sv - flash-side QSPI responder serving read-class commands
module qspi_target_responder
  import qspi_pkg::*;
#(
  parameter int ADDR_BYTES   = 3,
  parameter int DUMMY_CYCLES = 8,
  parameter int MEM_AW       = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk_i,
  input  logic              cs_n_i,
  input  logic [3:0]        io_i,
  output logic [3:0]        io_o,
  output logic [3:0]        io_oe_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic              mem_re_o,
  input  logic [7:0]        mem_rdata_i,
  input  logic [7:0]        status_i,
  output logic              busy_o
);

  localparam int ADDR_BITS = 8 * ADDR_BYTES;

  logic                 sclk_rise, sclk_fall, cs_n_s;
  logic [3:0]           io_s;
  state_t               state, next_state;
  logic [7:0]           cnt;
  logic [6:0]           cmd_sr;
  logic [ADDR_BITS-2:0] addr_sr;
  logic [MEM_AW-1:0]    addr;
  logic [1:0]           lane;
  logic                 dummy_en, status_mode, armed, driving, re_d;
  logic [2:0]           phase;
  logic [7:0]           sr, next_byte, cur_byte, opcode;
  logic [ADDR_BITS-1:0] addr_full;
  logic                 last_phase;

  qspi_pin_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .sclk_i    (sclk_i),
    .cs_n_i    (cs_n_i),
    .io_i      (io_i),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_n_s    (cs_n_s),
    .io_s      (io_s)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    opcode     = {cmd_sr, io_s[0]};
    addr_full  = {addr_sr, io_s[0]};
    last_phase = (lane == LANE_QUAD) ? (phase == 3'd1) : (phase == 3'd7);
    cur_byte   = status_mode ? status_i : next_byte;
    next_state = state;
    case (state)
      ST_IDLE:  if (armed && !cs_n_s) next_state = ST_CMD;
      ST_CMD:
        if (sclk_rise && cnt == 8'd7) begin
          case (opcode)
            OP_READ, OP_FAST_READ, OP_QUAD_OUT_READ: next_state = ST_ADDR;
            OP_READ_STATUS:                          next_state = ST_DATA;
            default:                                 next_state = ST_IGNORE;
          endcase
        end
      ST_ADDR:
        if (sclk_rise && cnt == 8'(ADDR_BITS - 1))
          next_state = (dummy_en && DUMMY_CYCLES > 0) ? ST_DUMMY : ST_DATA;
      ST_DUMMY: if (sclk_rise && cnt == 8'(DUMMY_CYCLES - 1)) next_state = ST_DATA;
      default:  ;
    endcase
    // Deselect outranks any edge seen in the same cycle.
    if (state != ST_IDLE && cs_n_s) next_state = ST_IDLE;
    busy_o  = (state != ST_IDLE);
    io_oe_o = (state == ST_DATA && driving) ? lane_oe(lane) : 4'h0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0; cmd_sr <= '0; addr_sr <= '0; addr <= '0;
      lane <= LANE_SINGLE; dummy_en <= 1'b0; status_mode <= 1'b0;
      armed <= 1'b0; driving <= 1'b0; re_d <= 1'b0; phase <= '0;
      sr <= '0; next_byte <= '0; io_o <= 4'h0; mem_addr_o <= '0; mem_re_o <= 1'b0;
    end else begin
      mem_re_o <= 1'b0;
      re_d     <= mem_re_o;
      if (cs_n_s) armed <= 1'b1;
      if (re_d) next_byte <= mem_rdata_i;
      if (state == ST_IDLE || cs_n_s) begin
        cnt <= '0; phase <= '0; driving <= 1'b0;
        if (state != ST_IDLE) io_o <= 4'h0;
      end else begin
        case (state)
          ST_CMD:
            if (sclk_rise) begin
              cmd_sr <= opcode[6:0];
              cnt    <= (cnt == 8'd7) ? 8'd0 : cnt + 8'd1;
              if (cnt == 8'd7) begin
                lane        <= (opcode == OP_QUAD_OUT_READ) ? LANE_QUAD : LANE_SINGLE;
                dummy_en    <= (opcode == OP_FAST_READ) || (opcode == OP_QUAD_OUT_READ);
                status_mode <= (opcode == OP_READ_STATUS);
              end
            end
          ST_ADDR:
            if (sclk_rise) begin
              addr_sr <= addr_full[ADDR_BITS-2:0];
              cnt     <= (cnt == 8'(ADDR_BITS - 1)) ? 8'd0 : cnt + 8'd1;
              if (cnt == 8'(ADDR_BITS - 1)) begin
                addr       <= addr_full[MEM_AW-1:0];
                mem_addr_o <= addr_full[MEM_AW-1:0];
                mem_re_o   <= 1'b1;
              end
            end
          ST_DUMMY:
            if (sclk_rise) cnt <= (cnt == 8'(DUMMY_CYCLES - 1)) ? 8'd0 : cnt + 8'd1;
          ST_DATA:
            if (sclk_fall) begin
              driving <= 1'b1;
              phase   <= last_phase ? 3'd0 : phase + 3'd1;
              if (lane == LANE_QUAD) begin
                io_o <= (phase == 3'd0) ? cur_byte[7:4] : sr[7:4];
                sr   <= (phase == 3'd0) ? {cur_byte[3:0], 4'h0} : {sr[3:0], 4'h0};
              end else begin
                io_o <= {2'b00, (phase == 3'd0) ? cur_byte[7] : sr[7], 1'b0};
                sr   <= (phase == 3'd0) ? {cur_byte[6:0], 1'b0} : {sr[6:0], 1'b0};
              end
              // Fetch the following byte while the last bit/nibble of this one is on the pads.
              if (last_phase && !status_mode) begin
                addr       <= addr + MEM_AW'(1);
                mem_addr_o <= addr + MEM_AW'(1);
                mem_re_o   <= 1'b1;
              end
            end
          default: ;
        endcase
      end
    end
  end

endmodule
